// File: rtl/noc_inj_if.sv
// PE-side message handshake and router-side flit/credit signals of the local injector.
// slave: the injector's view. master: the PE/router side that drives it.
interface noc_inj_if #(
  parameter int MAX_LEN = 4
);
  logic                   pe_valid;
  logic                   pe_ready;
  logic [1:0]             pe_dest;
  logic [2:0]             pe_len;
  logic [8*MAX_LEN-1:0]   pe_data;
  logic [7:0]             flit_out;
  logic                   flit_write;
  logic                   credit_ret;
  logic                   busy;

  modport master (
    output pe_valid, pe_dest, pe_len, pe_data, credit_ret,
    input  pe_ready, flit_out, flit_write, busy
  );

  modport slave (
    input  pe_valid, pe_dest, pe_len, pe_data, credit_ret,
    output pe_ready, flit_out, flit_write, busy
  );
endinterface

// File: rtl/noc_local_injector.sv
// Local injector: serialises one PE message into a head flit plus payload
// flits for the router's local input FIFO, with credit-based flow control.
// Optional macro NOC_INJ_PARITY_EN appends an XOR parity flit to every packet.
//
// state  | meaning
// IDLE   | waiting for a PE handshake (pe_ready high)
// HEAD   | sending head flit once a credit is available
// BODY   | sending payload byte idx_q, stalls while credits are zero
// PARITY | (NOC_INJ_PARITY_EN only) sending XOR of head and payload bytes
module noc_local_injector #(
  parameter int NODE_ID = 0,
  parameter int MAX_LEN = 4,
  parameter int CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  noc_inj_if.slave   bus
);
  localparam int              CW       = $clog2(CREDITS + 1);
  localparam logic [CW-1:0]   CRED_MAX = CW'(CREDITS);
  localparam logic [2:0]      LEN_MAX  = 3'(MAX_LEN);
  localparam logic [1:0]      SRC      = 2'(NODE_ID);

`ifdef NOC_INJ_PARITY_EN
  typedef enum logic [1:0] {IDLE, HEAD, BODY, PARITY} state_t;
  localparam state_t END_STATE = PARITY;
`else
  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
  localparam state_t END_STATE = IDLE;
`endif

  state_t               state, state_nxt;
  logic [1:0]           dest_q;
  logic [2:0]           len_q;
  logic [2:0]           idx_q;
  logic [8*MAX_LEN-1:0] data_q;
  logic [CW-1:0]        credits_q;
  logic [7:0]           flit_q;
  logic                 write_q;
  logic [7:0]           par_q;
  logic                 handshake, has_credit, emit, last_byte;
  logic [7:0]           head_flit, cur_byte, flit_nxt;

  assign handshake  = bus.pe_valid && bus.pe_ready;
  assign has_credit = (credits_q != '0);
  assign head_flit  = {1'b1, len_q, dest_q, SRC};
  assign last_byte  = (idx_q == len_q - 3'd1);

  assign bus.pe_ready   = (state == IDLE) && rst;
  assign bus.busy       = (state != IDLE);
  assign bus.flit_out   = flit_q;
  assign bus.flit_write = write_q;

  // Select the payload byte addressed by idx_q.
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (idx_q == 3'(i)) cur_byte = data_q[i*8 +: 8];
  end

  // Next-state and flit selection; a flit is emitted only when a credit is held.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    flit_nxt  = flit_q;
    case (state)
      IDLE: if (handshake) state_nxt = HEAD;
      HEAD: if (has_credit) begin
        emit      = 1'b1;
        flit_nxt  = head_flit;
        state_nxt = (len_q != 3'd0) ? BODY : END_STATE;
      end
      BODY: if (has_credit) begin
        emit     = 1'b1;
        flit_nxt = cur_byte;
        if (last_byte) state_nxt = END_STATE;
      end
`ifdef NOC_INJ_PARITY_EN
      PARITY: if (has_credit) begin
        emit      = 1'b1;
        flit_nxt  = par_q;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Message latch, byte index, credit counter, parity and registered flit outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dest_q    <= '0;
      len_q     <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      credits_q <= CRED_MAX;
      flit_q    <= '0;
      write_q   <= 1'b0;
      par_q     <= '0;
    end else begin
      write_q <= emit;
      flit_q  <= flit_nxt;
      if (handshake) begin
        dest_q <= bus.pe_dest;
        data_q <= bus.pe_data;
        len_q  <= (bus.pe_len > LEN_MAX) ? LEN_MAX : bus.pe_len;
      end
      if (emit && state == BODY)
        idx_q <= last_byte ? 3'd0 : idx_q + 3'd1;
      case ({emit, bus.credit_ret})
        2'b10:   credits_q <= credits_q - CW'(1);
        2'b01:   if (credits_q != CRED_MAX) credits_q <= credits_q + CW'(1);
        default: credits_q <= credits_q;
      endcase
      if (emit && state == HEAD)      par_q <= head_flit;
      else if (emit && state == BODY) par_q <= par_q ^ cur_byte;
    end
  end
endmodule

// File: tb/tb_noc_local_injector.sv
// Directed bench for noc_local_injector (NODE_ID=0, MAX_LEN=4, CREDITS=4).
// Follows NOC_INJ_PARITY_EN: expected packets gain a parity flit when defined.
module tb_noc_local_injector;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  noc_inj_if #(.MAX_LEN(4)) bus ();

  noc_local_injector #(.NODE_ID(0), .MAX_LEN(4), .CREDITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  dest;
    logic [2:0]  len;
    logic [31:0] data;
    logic        ret;
    logic [3:0]  n;
    logic [47:0] f;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_pkt(input logic [1:0] dest, input logic [2:0] len, input logic [31:0] data);
    int w = 0;
    while (!bus.pe_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_wait", {31'd0, bus.pe_ready}, 32'd1);
    bus.pe_valid = 1'b1;
    bus.pe_dest  = dest;
    bus.pe_len   = len;
    bus.pe_data  = data;
    @(posedge clk); #1;
    bus.pe_valid   = 1'b0;
    bus.credit_ret = 1'b0;
  endtask

  task automatic pulse_credits(input int k);
    for (int i = 0; i < k; i++) begin
      bus.credit_ret = 1'b1;
      @(posedge clk); #1;
    end
    bus.credit_ret = 1'b0;
  endtask

  task automatic run_pkt(input vec_t v, input string name);
    logic [55:0] expf;
    int exp_n, got, cyc, first;
    logic done;
    expf  = {8'h00, v.f};
    exp_n = int'(v.n);
`ifdef NOC_INJ_PARITY_EN
    begin
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < exp_n; i++) p ^= expf[i*8 +: 8];
      expf[exp_n*8 +: 8] = p;
      exp_n++;
    end
`endif
    start_pkt(v.dest, v.len, v.data);
    got = 0; cyc = 0; first = -1; done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      bus.credit_ret = 1'b0;
      if (bus.flit_write) begin
        if (got < exp_n) chk($sformatf("%s flit%0d", name, got), {24'd0, bus.flit_out}, {24'd0, expf[got*8 +: 8]});
        else chk($sformatf("%s extra_flit", name), 32'd1, 32'd0);
        got++;
        if (first < 0) first = cyc;
        if (v.ret) bus.credit_ret = 1'b1;
      end
      if (!bus.busy) done = 1'b1;
    end
    chk({name, " timeout"}, {31'd0, done}, 32'd1);
    chk({name, " count"}, got, exp_n);
    chk({name, " latency"}, first, 1);
    chk({name, " no_stall"}, cyc, exp_n);
    chk({name, " ready_after"}, {31'd0, bus.pe_ready}, 32'd1);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t vh;
    logic [47:0] exp_o;
    logic [5:0]  exp_w;

    vecs[0] = '{dest:2'b11, len:3'd3, data:32'h00C3B2A1, ret:1'b1, n:4'd4, f:48'h0000C3B2A1BC};
    vecs[1] = '{dest:2'b00, len:3'd0, data:32'hFFFFFFFF, ret:1'b1, n:4'd1, f:48'h000000000080};
    vecs[2] = '{dest:2'b10, len:3'd6, data:32'h44332211, ret:1'b1, n:4'd5, f:48'h0044332211C8};
    vecs[3] = '{dest:2'b01, len:3'd1, data:32'h0000005A, ret:1'b1, n:4'd2, f:48'h000000005A94};
    vecs[4] = '{dest:2'b10, len:3'd4, data:32'hDEADBEEF, ret:1'b1, n:4'd5, f:48'h00DEADBEEFC8};
    vecs[5] = '{dest:2'b01, len:3'd7, data:32'h01020304, ret:1'b1, n:4'd5, f:48'h0001020304C4};
    vecs[6] = '{dest:2'b01, len:3'd2, data:32'h0000F00F, ret:1'b1, n:4'd3, f:48'h000000F00FA4};
    vh      = '{dest:2'b11, len:3'd2, data:32'h0000B2A1, ret:1'b0, n:4'd3, f:48'h00000000B2A1AC};

    bus.pe_valid   = 1'b0;
    bus.pe_dest    = '0;
    bus.pe_len     = '0;
    bus.pe_data    = '0;
    bus.credit_ret = 1'b0;

    // Values held during reset.
    #2;
    chk("rst flit_write", {31'd0, bus.flit_write}, 32'd0);
    chk("rst flit_out", {24'd0, bus.flit_out}, 32'd0);
    chk("rst pe_ready", {31'd0, bus.pe_ready}, 32'd0);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("post_rst pe_ready", {31'd0, bus.pe_ready}, 32'd1);

    // Idle with credit returns pulsing: nothing written, counter saturates.
    for (int i = 0; i < 4; i++) begin
      bus.credit_ret = (i % 2 == 0);
      @(posedge clk); #1;
      chk("idle flit_write", {31'd0, bus.flit_write}, 32'd0);
      chk("idle flit_out", {24'd0, bus.flit_out}, 32'd0);
      chk("idle pe_ready", {31'd0, bus.pe_ready}, 32'd1);
    end
    bus.credit_ret = 1'b0;

    // Credit exhaustion: four flits go, the fifth waits for one credit return.
    exp_o = 48'h3333_3322_11CC;
    exp_w = 6'b001111;
    start_pkt(2'b11, 3'd4, 32'h44332211);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall w%0d", i), {31'd0, bus.flit_write}, {31'd0, exp_w[i]});
      chk($sformatf("stall o%0d", i), {24'd0, bus.flit_out}, {24'd0, exp_o[i*8 +: 8]});
      chk($sformatf("stall busy%0d", i), {31'd0, bus.busy}, 32'd1);
    end
    bus.credit_ret = 1'b1;
    @(posedge clk); #1;
    bus.credit_ret = 1'b0;
    chk("stall ret_edge write", {31'd0, bus.flit_write}, 32'd0);
    @(posedge clk); #1;
    chk("stall last write", {31'd0, bus.flit_write}, 32'd1);
    chk("stall last out", {24'd0, bus.flit_out}, 32'h44);
`ifdef NOC_INJ_PARITY_EN
    chk("stall busy_before_parity", {31'd0, bus.busy}, 32'd1);
    bus.credit_ret = 1'b1;
    @(posedge clk); #1;
    bus.credit_ret = 1'b0;
    @(posedge clk); #1;
    chk("stall parity write", {31'd0, bus.flit_write}, 32'd1);
    chk("stall parity out", {24'd0, bus.flit_out}, 32'h88);
`endif
    chk("stall busy_end", {31'd0, bus.busy}, 32'd0);
    pulse_credits(4);

    // Back-to-back table with a credit returned for every flit written.
    for (int i = 0; i < 7; i++) run_pkt(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a packet.
    start_pkt(2'b10, 3'd4, 32'h55667788);
    @(posedge clk); #1;
    chk("abort head", {24'd0, bus.flit_out}, 32'hC8);
    @(posedge clk); #1;
    chk("abort byte0", {24'd0, bus.flit_out}, 32'h88);
    chk("abort busy_before", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort flit_write", {31'd0, bus.flit_write}, 32'd0);
    chk("abort flit_out", {24'd0, bus.flit_out}, 32'd0);
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort pe_ready", {31'd0, bus.pe_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_pkt(vh, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/noc_local_injector.md
Name: noc_local_injector

Overview:
- Network interface stage directly upstream of the router's local input port (port 0).
- Accepts one message at a time from the processing element (PE) and serialises it into 8-bit flits: one head flit, then payload flits.
- Drives the router's local input FIFO (data and write strobe).
- Uses credit-based flow control, so the router FIFO is never overrun.

Parameters:
- NODE_ID, 0, 2-bit mesh address {y,x} of this node; inserted as the source field of the head flit.
- MAX_LEN, 4, maximum payload bytes per message (1..7).
- CREDITS, 4, depth of the router local FIFO; initial credit count.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- pe_valid  input  1  PE offers a message.
- pe_ready  output  1  injector can accept a message this cycle.
- pe_dest  input  2  destination node {y,x}.
- pe_len  input  3  payload byte count.
- pe_data  input  8*MAX_LEN  payload; byte 0 is in bits [7:0] and is sent first.
- flit_out  output  8  flit to the router local FIFO data input.
- flit_write  output  1  write strobe to the router local FIFO; one flit per asserted cycle.
- credit_ret  input  1  one-cycle pulse each time the router pops a flit from its local FIFO.
- busy  output  1  message in flight (FSM not IDLE).

Behaviour:
- Reset (rst low, asynchronous):
  - FSM=IDLE, credit counter=CREDITS, byte index=0.
  - flit_out=8'h00, flit_write=0, pe_ready=0, busy=0.
  - Asserting rst mid-packet aborts the packet; the flits already written are not retracted.
- Head flit format:
  - bit7=1.
  - bits6:4 = effective length.
  - bits3:2 = dest.
  - bits1:0 = NODE_ID.
- Payload flit format: raw byte.
- pe_ready = (state==IDLE) and not in reset.
  - A handshake occurs when pe_valid & pe_ready.
  - On handshake, latch pe_dest, pe_data, and effective length = min(pe_len, MAX_LEN).
- FSM:
  - IDLE -> HEAD on handshake.
  - HEAD:
    - When credits>0: emit the head flit (flit_write=1), decrement credits.
    - Then go to BODY if length>0, else IDLE.
    - When credits==0: hold, flit_write=0.
  - BODY:
    - When credits>0: emit byte[index], increment index.
    - After the last byte (index==length-1): go to IDLE and clear index.
    - When credits==0: stall, index unchanged.
- Outputs are registered:
  - flit_out and flit_write are updated on the edge that consumes the credit.
  - First-flit latency: the head is visible the cycle after the handshake, if credit is available.
  - Back-to-back: the next handshake is possible the cycle after the last flit is written, because IDLE is re-entered.
- flit_out holds its last value when flit_write=0.
- Credit counter (width clog2(CREDITS+1)):
  - Write without credit_ret: -1.
  - credit_ret without write: +1.
  - Both in the same cycle: unchanged.
  - credit_ret while counter==CREDITS: ignored (saturate). The counter never underflows.
- pe_len=0: head-only packet with length field 0.
- pe_len>MAX_LEN: clamped to MAX_LEN. The extra bytes are ignored.
- dest==NODE_ID: injected normally; the router handles loopback to its local output.

Optional Feature:
- Macro: NOC_INJ_PARITY_EN.
- When defined:
  - After the last payload flit (or directly after the head if length=0), the FSM enters state PARITY.
  - PARITY emits one extra flit, subject to the same credit rule: the XOR of the head flit and all payload bytes.
  - The head length field still counts payload bytes only.
  - Packet occupancy is length+2 flits.
- When undefined: no PARITY state; occupancy is length+1 flits.

Test Plan (NODE_ID=0, CREDITS=4, MAX_LEN=4, macro undefined unless stated):
- Reset, then idle with credit_ret pulsing -> flit_write=0, flit_out=00, pe_ready=1 from the first cycle after rst deasserts, credit count stays 4.
- pe_dest=2'b11, pe_len=3, bytes A1,B2,C3, credit_ret tied 0 -> flits B C, A1, B2, C3 on 4 consecutive cycles, then busy=0.
- pe_len=4, bytes 11..44, credit_ret tied 0 -> head 0xCC plus 3 bytes sent. Credits are then exhausted and 44 stalls. One credit_ret pulse -> 44 is written 1 cycle later.
- Sustained traffic with credit_ret pulsing on the same cycle as each write -> counter remains constant and no stall occurs. pe_len=6 -> head length field=4, exactly 4 payload flits.
- rst asserted during BODY after 2 flits -> outputs go to reset values immediately, credits=4, next message starts with a fresh head.
- NOC_INJ_PARITY_EN, dest=01, len=2, bytes 0F,F0 -> flits A4, 0F, F0, then parity 5B (=A4^0F^F0).
